// File: rtl/exe_unit_w6.sv
// ---------------------------------------------------------------------------
// exe_unit_w6 -- single-cycle sign-magnitude execution unit.
//
// A combinational datapath computes one of four operations and feeds a single
// output register, so every result appears exactly one i_clk edge after its
// operands were presented. The unit has no handshake: a new operation is
// accepted on every cycle and nothing is held back.
//
// Ports
//   i_clk     : clock, all state changes on the rising edge
//   i_rst     : synchronous reset, active low; clears o_out and o_status
//   i_a       : operand A, sign-magnitude (MSB = sign)
//   i_b       : operand B, sign-magnitude for subtract/compare,
//               unsigned shift amount / bit index for shift/toggle
//   i_op      : 00 subtract, 01 compare (A > B), 10 shift left, 11 bit toggle
//   o_out     : registered result
//   o_status  : registered flags {ERR, EVEN, SINGLE, OVF}
// ---------------------------------------------------------------------------
module exe_unit_w6 #(
    parameter int BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic [1:0]      i_op,
    output logic [BITS-1:0] o_out,
    output logic [3:0]      o_status
);

    localparam int          MW      = BITS - 1;           // magnitude width
    localparam logic [BITS-1:0] MAX_IDX = BITS'(BITS - 1); // highest legal bit index

    localparam logic [1:0] OP_SUB = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    // ---------------------------------------------------------------------
    // Signed views of the sign-magnitude operands. One extra bit is enough
    // to hold +/-(2^(BITS-1)-1); +0 and -0 both map to 0.
    // ---------------------------------------------------------------------
    logic signed [BITS:0]   a_val;
    logic signed [BITS:0]   b_val;
    logic signed [BITS:0]   a_mag_s;
    logic signed [BITS:0]   b_mag_s;

    assign a_mag_s = $signed({2'b00, i_a[MW-1:0]});
    assign b_mag_s = $signed({2'b00, i_b[MW-1:0]});
    assign a_val   = i_a[BITS-1] ? -a_mag_s : a_mag_s;
    assign b_val   = i_b[BITS-1] ? -b_mag_s : b_mag_s;

    // Full-precision difference: one more bit than the operands so that
    // +/-2*(2^(BITS-1)-1) never wraps.
    logic signed [BITS+1:0] diff;
    logic        [BITS+1:0] diff_abs;

    assign diff     = $signed({a_val[BITS], a_val}) - $signed({b_val[BITS], b_val});
    assign diff_abs = diff[BITS+1] ? -diff : diff;

    // Left shift in a double-width field so bits pushed out of the magnitude
    // are still visible for overflow detection.
    logic [2*MW-1:0] shl_wide;

    assign shl_wide = {{MW{1'b0}}, i_a[MW-1:0]} << i_b;

    // One-hot mask for the toggle operation.
    logic [BITS-1:0] tgl_mask;

    assign tgl_mask = {{(BITS-1){1'b0}}, 1'b1} << i_b;

    // ---------------------------------------------------------------------
    // Result selection
    // ---------------------------------------------------------------------
    logic [BITS-1:0] raw_res;
    logic [BITS-1:0] res;
    logic            err;
    logic            ovf;
    logic            b_too_big;

    assign b_too_big = (i_b > MAX_IDX);

    always_comb begin
        raw_res = '0;
        err     = 1'b0;
        ovf     = 1'b0;
        unique case (i_op)
            OP_SUB: begin
                raw_res = {diff[BITS+1], diff_abs[MW-1:0]};
                ovf     = |diff_abs[BITS+1:MW];
            end
            OP_CMP: begin
                raw_res = {{(BITS-1){1'b0}}, (a_val > b_val)};
            end
            OP_SHL: begin
                // A set sign bit in B is a negative shift amount and is rejected.
                err     = i_b[BITS-1] | b_too_big;
                raw_res = {i_a[BITS-1], shl_wide[MW-1:0]};
                ovf     = |shl_wide[2*MW-1:MW];
            end
            OP_TGL: begin
                err     = b_too_big;
                raw_res = i_a ^ tgl_mask;
            end
            default: begin
                raw_res = '0;
            end
        endcase

        // Errors force a clean zero result with no other flags. Any
        // negative zero is folded to all-zero so it never leaves the unit.
        if (err) begin
            res = '0;
            ovf = 1'b0;
        end else if (raw_res[MW-1:0] == '0) begin
            res = '0;
        end else begin
            res = raw_res;
        end
    end

    logic even_d;
    logic single_d;

    assign single_d = ~err & (^res);
    assign even_d   = ~err & ~(^res);

    // ---------------------------------------------------------------------
    // Output register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_out    <= '0;
            o_status <= 4'b0000;
        end else begin
            o_out    <= res;
            o_status <= {err, even_d, single_d, ovf};
        end
    end

endmodule

// File: tb/tb_exe_unit_w6.sv
// ---------------------------------------------------------------------------
// tb_exe_unit_w6 -- directed bench for exe_unit_w6 (BITS = 8).
//
// Each step drives one operation on the falling edge, lets one rising edge
// capture it, then checks o_out and o_status just after that edge against
// hand-computed values. Steps follow each other with no idle cycles, so the
// sequence also covers back-to-back operation changes.
// ---------------------------------------------------------------------------
module tb_exe_unit_w6;

    localparam int BITS = 8;

    logic            clk;
    logic            i_rst;
    logic [BITS-1:0] i_a;
    logic [BITS-1:0] i_b;
    logic [1:0]      i_op;
    logic [BITS-1:0] o_out;
    logic [3:0]      o_status;

    int total;
    int bad;

    exe_unit_w6 #(.BITS(BITS)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_op     (i_op),
        .o_out    (o_out),
        .o_status (o_status)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver + checker for one operation
    task automatic step(input logic rst_n, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_out, input logic [3:0] exp_stat,
                        input string tag);
        @(negedge clk);
        i_rst = rst_n;
        i_op  = op;
        i_a   = a;
        i_b   = b;
        @(posedge clk);
        #1;
        total++;
        assert (o_out === exp_out) else begin
            bad++;
            $error("FAIL %s out: got %h want %h", tag, o_out, exp_out);
        end
        total++;
        assert (o_status === exp_stat) else begin
            bad++;
            $error("FAIL %s status: got %b want %b", tag, o_status, exp_stat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst = 1'b0;
        i_op  = 2'b00;
        i_a   = '0;
        i_b   = '0;

        // Reset dominates whatever operation is presented
        step(1'b0, 2'b10, 8'hFF, 8'h01, 8'h00, 4'b0000, "rst_shift");
        step(1'b0, 2'b00, 8'h7F, 8'h81, 8'h00, 4'b0000, "rst_sub");

        // Subtract
        step(1'b1, 2'b00, 8'd91, 8'd41, 8'h32, 4'b0010, "sub_91_41");
        step(1'b1, 2'b00, 8'h7F, 8'h81, 8'h00, 4'b0101, "sub_ovf");
        step(1'b1, 2'b00, 8'h85, 8'h05, 8'h8A, 4'b0010, "sub_neg");
        step(1'b1, 2'b00, 8'h05, 8'h85, 8'h0A, 4'b0100, "sub_pos_neg");
        step(1'b1, 2'b00, 8'h80, 8'h00, 8'h00, 4'b0100, "sub_negzero");
        step(1'b1, 2'b00, 8'h81, 8'h7F, 8'h00, 4'b0101, "sub_ovf_negzero");

        // Compare
        step(1'b1, 2'b01, 8'hB2, 8'h04, 8'h00, 4'b0100, "cmp_neg_lt");
        step(1'b1, 2'b01, 8'd90, 8'd40, 8'h01, 4'b0010, "cmp_gt");
        step(1'b1, 2'b01, 8'h00, 8'h80, 8'h00, 4'b0100, "cmp_pz_nz");
        step(1'b1, 2'b01, 8'h80, 8'h00, 8'h00, 4'b0100, "cmp_nz_pz");
        step(1'b1, 2'b01, 8'h01, 8'h81, 8'h01, 4'b0010, "cmp_1_m1");

        // Shift
        step(1'b1, 2'b10, 8'h09, 8'h01, 8'h12, 4'b0100, "shl_9_1");
        step(1'b1, 2'b10, 8'hFF, 8'h01, 8'hFE, 4'b0011, "shl_ovf_ff");
        step(1'b1, 2'b10, 8'h06, 8'h05, 8'h40, 4'b0011, "shl_ovf_6_5");
        step(1'b1, 2'b10, 8'h81, 8'h02, 8'h84, 4'b0100, "shl_neg");
        step(1'b1, 2'b10, 8'hC1, 8'h81, 8'h00, 4'b1000, "shl_err_negb");
        step(1'b1, 2'b10, 8'h01, 8'h07, 8'h00, 4'b0101, "shl_max_idx");
        step(1'b1, 2'b10, 8'h01, 8'h08, 8'h00, 4'b1000, "shl_err_8");
        step(1'b1, 2'b10, 8'hC0, 8'h01, 8'h00, 4'b0101, "shl_negzero");

        // Toggle
        step(1'b1, 2'b11, 8'hB0, 8'h00, 8'hB1, 4'b0100, "tgl_b0_0");
        step(1'b1, 2'b11, 8'hFC, 8'h01, 8'hFE, 4'b0010, "tgl_fc_1");
        step(1'b1, 2'b11, 8'h00, 8'h70, 8'h00, 4'b1000, "tgl_err_70");
        step(1'b1, 2'b11, 8'h00, 8'h81, 8'h00, 4'b1000, "tgl_err_81");
        step(1'b1, 2'b11, 8'h01, 8'h07, 8'h81, 4'b0100, "tgl_bit7");
        step(1'b1, 2'b11, 8'h00, 8'h07, 8'h00, 4'b0100, "tgl_negzero");
        step(1'b1, 2'b11, 8'h01, 8'h08, 8'h00, 4'b1000, "tgl_err_8");

        // Reset mid-stream discards the in-flight result, then recovery
        step(1'b1, 2'b10, 8'h09, 8'h01, 8'h12, 4'b0100, "pre_rst");
        step(1'b0, 2'b00, 8'd91, 8'd41, 8'h00, 4'b0000, "mid_rst");
        step(1'b1, 2'b00, 8'd91, 8'd41, 8'h32, 4'b0010, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_unit_w6.md
EXE_UNIT_W6 -- requirements
Module: exe_unit_w6

Interface
REQ-001 The block SHALL have parameter BITS, default 8, giving the operand/result width (BITS >= 4).
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1, the reset; it is synchronous and active-low.
REQ-004 The block SHALL have port i_a, input, BITS, operand A, sign-magnitude (MSB = sign, low BITS-1 bits = magnitude).
REQ-005 The block SHALL have port i_b, input, BITS, operand B, sign-magnitude for ops 00/01, unsigned for ops 10/11.
REQ-006 The block SHALL have port i_op, input, 2, the operation select: 00 subtract, 01 compare, 10 shift, 11 bit toggle.
REQ-007 The block SHALL have port o_out, output, BITS, the registered result.
REQ-008 The block SHALL have port o_status, output, 4, the registered flags {ERR, EVEN, SINGLE, OVF} at bits [3:0] = {3,2,1,0}.

Function
REQ-009 o_out and o_status SHALL be registered, updating one i_clk edge after operands and op are sampled (latency 1, no handshake, a new operation every cycle).
REQ-010 Op 00 SHALL compute A - B in sign-magnitude with a full-precision intermediate; result magnitude = |A-B| mod 2^(BITS-1); sign = sign of the true difference.
REQ-011 Op 00 SHALL set OVF when |A-B| > 2^(BITS-1)-1.
REQ-012 Op 01 SHALL output 1 when signed A > signed B, else 0; +0 and -0 compare equal.
REQ-013 Op 10 SHALL raise ERR when i_b[BITS-1] = 1 or i_b > BITS-1.
REQ-014 Op 10 without ERR SHALL left-shift the magnitude of A by i_b, keeping the low BITS-1 bits and preserving A's sign bit.
REQ-015 Op 10 SHALL set OVF when any 1 bit is shifted out of the magnitude field.
REQ-016 Op 11 SHALL raise ERR when i_b > BITS-1.
REQ-017 Op 11 without ERR SHALL output A with bit i_b inverted; OVF is always 0.
REQ-018 Ops 00 and 01 SHALL never raise ERR.
REQ-019 When ERR = 1, o_out SHALL be 0 and EVEN, SINGLE and OVF SHALL be 0.
REQ-020 Any negative-zero result (sign 1, magnitude 0) SHALL be normalised to all-zero before output.
REQ-021 When ERR = 0, EVEN SHALL be 1 iff o_out has an even number of 1 bits (including zero ones).
REQ-022 When ERR = 0, SINGLE SHALL be 1 iff o_out has an odd number of 1 bits.
REQ-023 When ERR = 0, exactly one of EVEN and SINGLE SHALL be 1.
REQ-024 The datapath SHALL be purely combinational into the output register, with no other internal state.

Reset
REQ-025 While i_rst = 0 at a rising edge, o_out SHALL become 0 and o_status SHALL become 4'b0000, regardless of the other inputs.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-027 The first valid result SHALL appear on the first edge with i_rst = 1.
REQ-028 Output values before the first clock edge SHALL NOT be checked.

Verification
REQ-029 i_rst=0 with op=10, A=0xFF, B=0x01 -> o_out=0x00, o_status=0000 on the next edge.
REQ-030 op=00: A=91, B=41 -> 0x32, status 0010; A=0x7F, B=0x81 -> 0x00, status 0101 (overflow).
REQ-031 op=01: A=0xB2 (-50), B=0x04 -> 0x00, status 0100; A=90, B=40 -> 0x01, status 0010.
REQ-032 op=10: A=0x09, B=1 -> 0x12, status 0100.
REQ-033 op=10 overflow cases: A=0xFF, B=1 -> 0xFE, status 0011; A=0x06, B=5 -> 0x40, status 0011.
REQ-034 op=10: A=0x81, B=2 -> 0x84, status 0100; A=0xC1, B=0x81 -> 0x00, status 1000.
REQ-035 op=11: A=0xB0, B=0 -> 0xB1, status 0100; A=0xFC, B=1 -> 0xFE, status 0010; A=0x00, B=0x70 or B=0x81 -> 0x00, status 1000.
REQ-036 Back-to-back ops changing every cycle SHALL each produce their result exactly one edge later.
